// File: rtl/rob_commit_unit_pkg.sv
// ----------------------------------------------------------------------------
// rob_commit_unit_pkg
// Shared types for the ROB commit consumer:
//   RobEntrySt / RobCmtSt  - what the ReorderBuffer presents each cycle
//   BpuUpdateSt            - branch predictor training record
//   CmtExcpSt              - exception record handed to CSR
//   CMT_RUN/FLUSH/SLEEP    - commit FSM state encodings
//   cmt_event_e            - per-slot flush-class event kind
// ----------------------------------------------------------------------------
package rob_commit_unit_pkg;

    localparam int CMT_WIDTH  = 2;
    localparam int ARCH_REGS  = 32;
    localparam int PHY_REGS   = 64;
    localparam int ARCH_IDX_W = $clog2(ARCH_REGS);
    localparam int PHY_IDX_W  = $clog2(PHY_REGS);

    // instr_type encodings carried in each ROB entry
    localparam logic [1:0] ALU_INSTR  = 2'd0;
    localparam logic [1:0] BR_INSTR   = 2'd1;
    localparam logic [1:0] MEM_INSTR  = 2'd2;
    localparam logic [1:0] PRIV_INSTR = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } RobExcpSt;

    typedef struct packed {
        logic [31:0]           pc;
        logic [1:0]            instr_type;
        logic [ARCH_IDX_W-1:0] arch_reg;
        logic [PHY_IDX_W-1:0]  phy_reg;
        logic [PHY_IDX_W-1:0]  old_phy_reg;
        logic                  old_phy_reg_valid;
        RobExcpSt              excp;
        logic [31:0]           error_vaddr;
        logic                  ertn_flush;
        logic                  br_redirect;
        logic [31:0]           br_target;
        logic [1:0]            br_type;
        logic                  br_taken;
        logic                  idle_flush;
        logic                  priv_flush;
        logic                  ibar_flush;
        logic                  icacop_flush;
    } RobEntrySt;

    typedef struct packed {
        logic [CMT_WIDTH-1:0]      valid;
        RobEntrySt [CMT_WIDTH-1:0] rob_entry;
    } RobCmtSt;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  br_type;
        logic        taken;
        logic [31:0] target;
    } BpuUpdateSt;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
        logic [31:0] badv;
    } CmtExcpSt;

    // Commit FSM states
    localparam logic [1:0] CMT_RUN   = 2'd0;
    localparam logic [1:0] CMT_FLUSH = 2'd1;
    localparam logic [1:0] CMT_SLEEP = 2'd2;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXCP,
        EV_ERTN,
        EV_BR,
        EV_IDLE,
        EV_PRIV
    } cmt_event_e;

endpackage

// File: rtl/rob_commit_unit_if.sv
// ----------------------------------------------------------------------------
// rob_commit_unit_if
// Commit bus from the ReorderBuffer to the commit unit.
//   cmt : RobCmtSt, valid[i] + rob_entry[i] per retire slot
// Handshake: valid-only. The ROB drives valid[i]/rob_entry[i] and the commit
// unit consumes every valid slot in that same cycle; there is no ready,
// because retirement is never back-pressured. Slots dropped behind a flush
// event are simply discarded with the rest of the pipeline.
//   master : ROB side (drives cmt)
//   slave  : commit unit side (reads cmt)
// ----------------------------------------------------------------------------
interface rob_commit_unit_if;
    import rob_commit_unit_pkg::*;

    RobCmtSt cmt;

    modport master (output cmt);
    modport slave  (input  cmt);

endinterface

// File: rtl/rob_commit_unit_event_sel.sv
// ----------------------------------------------------------------------------
// rob_commit_unit_event_sel
// Combinational per-slot flush-event priority plus first-event pick.
//   cmt         in  : commit bus contents
//   act         out : slot retires this cycle (valid and not behind an event)
//   ev_kind     out : event of the first event-carrying slot (EV_NONE if none)
//   ev_pc       out : pc of that slot
//   ev_target   out : br_target of that slot
//   ev_ecode    out : exception ecode of that slot
//   ev_esubcode out : exception esubcode of that slot
//   ev_badv     out : error_vaddr of that slot
// ----------------------------------------------------------------------------
module rob_commit_unit_event_sel
    import rob_commit_unit_pkg::*;
(
    input  RobCmtSt              cmt,
    output logic [CMT_WIDTH-1:0] act,
    output cmt_event_e           ev_kind,
    output logic [31:0]          ev_pc,
    output logic [31:0]          ev_target,
    output logic [5:0]           ev_ecode,
    output logic [8:0]           ev_esubcode,
    output logic [31:0]          ev_badv
);

    cmt_event_e slot_ev [CMT_WIDTH];
    logic       stop;
    logic       unused_cmt;

    // Only a subset of entry fields matter here; fold the rest into a sink.
    assign unused_cmt = ^cmt;

    // Per-slot priority: exception > ertn > branch redirect > idle > priv-class
    always_comb begin
        for (int i = 0; i < CMT_WIDTH; i++) begin
            slot_ev[i] = EV_NONE;
            if (cmt.rob_entry[i].excp.valid)
                slot_ev[i] = EV_EXCP;
            else if (cmt.rob_entry[i].ertn_flush)
                slot_ev[i] = EV_ERTN;
            else if (cmt.rob_entry[i].br_redirect)
                slot_ev[i] = EV_BR;
            else if (cmt.rob_entry[i].idle_flush)
                slot_ev[i] = EV_IDLE;
            else if (cmt.rob_entry[i].priv_flush | cmt.rob_entry[i].ibar_flush |
                     cmt.rob_entry[i].icacop_flush)
                slot_ev[i] = EV_PRIV;
        end
    end

    // The event-carrying slot itself still acts; everything after it is dropped.
    always_comb begin
        act         = '0;
        stop        = 1'b0;
        ev_kind     = EV_NONE;
        ev_pc       = '0;
        ev_target   = '0;
        ev_ecode    = '0;
        ev_esubcode = '0;
        ev_badv     = '0;
        for (int i = 0; i < CMT_WIDTH; i++) begin
            if (!stop && cmt.valid[i]) begin
                act[i] = 1'b1;
                if (slot_ev[i] != EV_NONE) begin
                    stop        = 1'b1;
                    ev_kind     = slot_ev[i];
                    ev_pc       = cmt.rob_entry[i].pc;
                    ev_target   = cmt.rob_entry[i].br_target;
                    ev_ecode    = cmt.rob_entry[i].excp.ecode;
                    ev_esubcode = cmt.rob_entry[i].excp.esubcode;
                    ev_badv     = cmt.rob_entry[i].error_vaddr;
                end
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// ----------------------------------------------------------------------------
// rob_commit_unit
// Consumer of the ROB commit bus. Performs architectural side effects of up to
// COMMIT_WIDTH retiring entries per cycle and turns flush-class events into a
// single flush pulse plus redirect PC. All outputs are registered.
//   clk, rst        : clock, synchronous active-high reset
//   cmt_i           : commit bus (slave modport)
//   eentry_i, era_i : exception entry / ertn return address from CSR
//   intr_i          : pending interrupt, wakes from SLEEP
//   arat_we_o/idx/preg : architectural RAT update
//   fl_free_o/preg  : free-list release of old physical registers
//   bpu_upd_o       : branch predictor training
//   excp_o, ertn_o  : exception / ertn retired
//   flush_o, redirect_pc_o : one-cycle flush pulse with target
//   stall_o         : frontend hold while sleeping
//   retired_cnt_o   : retired-instruction counter (wraps)
//   dbg_state_o     : commit FSM state
// ----------------------------------------------------------------------------
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int ARCH_REG_NUM = 32,
    parameter int PHY_REG_NUM  = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    rob_commit_unit_if.slave                                  cmt_i,
    input  logic [31:0]                                       eentry_i,
    input  logic [31:0]                                       era_i,
    input  logic                                              intr_i,
    output logic [COMMIT_WIDTH-1:0]                           arat_we_o,
    output logic [COMMIT_WIDTH-1:0][$clog2(ARCH_REG_NUM)-1:0] arat_idx_o,
    output logic [COMMIT_WIDTH-1:0][$clog2(PHY_REG_NUM)-1:0]  arat_preg_o,
    output logic [COMMIT_WIDTH-1:0]                           fl_free_o,
    output logic [COMMIT_WIDTH-1:0][$clog2(PHY_REG_NUM)-1:0]  fl_preg_o,
    output BpuUpdateSt                                        bpu_upd_o,
    output CmtExcpSt                                          excp_o,
    output logic                                              ertn_o,
    output logic                                              flush_o,
    output logic [31:0]                                       redirect_pc_o,
    output logic                                              stall_o,
    output logic [63:0]                                       retired_cnt_o,
    output logic [1:0]                                        dbg_state_o
);

    localparam int INC_W = $clog2(COMMIT_WIDTH + 1);

    logic [1:0]              state;
    logic [31:0]             idle_pc;
    logic                    run;
    logic [COMMIT_WIDTH-1:0] act;
    logic [COMMIT_WIDTH-1:0] rat_ok;
    logic [COMMIT_WIDTH-1:0] we_n;
    logic [INC_W-1:0]        ret_inc;
    BpuUpdateSt              bpu_n;
    logic                    bpu_found;
    cmt_event_e              ev_kind;
    logic [31:0]             ev_pc;
    logic [31:0]             ev_target;
    logic [5:0]              ev_ecode;
    logic [8:0]              ev_esubcode;
    logic [31:0]             ev_badv;

    assign run         = (state == CMT_RUN);
    assign dbg_state_o = state;

    rob_commit_unit_event_sel u_event_sel (
        .cmt         (cmt_i.cmt),
        .act         (act),
        .ev_kind     (ev_kind),
        .ev_pc       (ev_pc),
        .ev_target   (ev_target),
        .ev_ecode    (ev_ecode),
        .ev_esubcode (ev_esubcode),
        .ev_badv     (ev_badv)
    );

    // RAT/free-list eligibility, write collapsing and retire count
    always_comb begin
        rat_ok  = '0;
        ret_inc = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rat_ok[i] = run & act[i] & cmt_i.cmt.rob_entry[i].old_phy_reg_valid &
                        ~cmt_i.cmt.rob_entry[i].excp.valid;
            if (run && act[i] && !cmt_i.cmt.rob_entry[i].excp.valid)
                ret_inc = ret_inc + INC_W'(1);
        end
        // A younger slot writing the same arch reg wins the RAT; both old
        // mappings are still released.
        we_n = rat_ok;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
                if (rat_ok[j] &&
                    cmt_i.cmt.rob_entry[j].arch_reg == cmt_i.cmt.rob_entry[i].arch_reg)
                    we_n[i] = 1'b0;
            end
        end
    end

    // BPU training from the oldest acting branch only
    always_comb begin
        bpu_n     = '0;
        bpu_found = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!bpu_found && run && act[i] &&
                cmt_i.cmt.rob_entry[i].instr_type == BR_INSTR) begin
                bpu_found     = 1'b1;
                bpu_n.valid   = 1'b1;
                bpu_n.pc      = cmt_i.cmt.rob_entry[i].pc;
                bpu_n.br_type = cmt_i.cmt.rob_entry[i].br_type;
                bpu_n.taken   = cmt_i.cmt.rob_entry[i].br_taken;
                bpu_n.target  = cmt_i.cmt.rob_entry[i].br_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= CMT_RUN;
            idle_pc       <= '0;
            arat_we_o     <= '0;
            arat_idx_o    <= '0;
            arat_preg_o   <= '0;
            fl_free_o     <= '0;
            fl_preg_o     <= '0;
            bpu_upd_o     <= '0;
            excp_o        <= '0;
            ertn_o        <= 1'b0;
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
            stall_o       <= 1'b0;
            retired_cnt_o <= '0;
        end else begin
            arat_we_o <= we_n;
            fl_free_o <= rat_ok;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                arat_idx_o[i]  <= cmt_i.cmt.rob_entry[i].arch_reg;
                arat_preg_o[i] <= cmt_i.cmt.rob_entry[i].phy_reg;
                fl_preg_o[i]   <= cmt_i.cmt.rob_entry[i].old_phy_reg;
            end
            bpu_upd_o     <= bpu_n;
            excp_o        <= '0;
            ertn_o        <= 1'b0;
            flush_o       <= 1'b0;
            retired_cnt_o <= retired_cnt_o + 64'(ret_inc);

            case (state)
                CMT_RUN: begin
                    case (ev_kind)
                        EV_EXCP: begin
                            state          <= CMT_FLUSH;
                            flush_o        <= 1'b1;
                            redirect_pc_o  <= eentry_i;
                            excp_o.valid    <= 1'b1;
                            excp_o.ecode    <= ev_ecode;
                            excp_o.esubcode <= ev_esubcode;
                            excp_o.pc       <= ev_pc;
                            excp_o.badv     <= ev_badv;
                        end
                        EV_ERTN: begin
                            state         <= CMT_FLUSH;
                            flush_o       <= 1'b1;
                            redirect_pc_o <= era_i;
                            ertn_o        <= 1'b1;
                        end
                        EV_BR: begin
                            state         <= CMT_FLUSH;
                            flush_o       <= 1'b1;
                            redirect_pc_o <= ev_target;
                        end
                        EV_IDLE: begin
                            // Interrupt is only honoured once actually asleep
                            state   <= CMT_SLEEP;
                            stall_o <= 1'b1;
                            idle_pc <= ev_pc + 32'd4;
                        end
                        EV_PRIV: begin
                            state         <= CMT_FLUSH;
                            flush_o       <= 1'b1;
                            redirect_pc_o <= ev_pc + 32'd4;
                        end
                        default: ;
                    endcase
                end
                CMT_FLUSH: state <= CMT_RUN;
                CMT_SLEEP: begin
                    if (intr_i) begin
                        state         <= CMT_FLUSH;
                        flush_o       <= 1'b1;
                        redirect_pc_o <= idle_pc;
                        stall_o       <= 1'b0;
                    end
                end
                default: state <= CMT_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// ----------------------------------------------------------------------------
// tb_rob_commit_unit
// Self-checking bench for rob_commit_unit. Inputs change on the falling edge,
// outputs are sampled on the following falling edge.
// ----------------------------------------------------------------------------
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    localparam int OW = 38 + $bits(BpuUpdateSt) + $bits(CmtExcpSt) + 99;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] eentry_i;
    logic [31:0] era_i;
    logic        intr_i;

    logic [1:0]      arat_we_o;
    logic [1:0][4:0] arat_idx_o;
    logic [1:0][5:0] arat_preg_o;
    logic [1:0]      fl_free_o;
    logic [1:0][5:0] fl_preg_o;
    BpuUpdateSt      bpu_upd_o;
    CmtExcpSt        excp_o;
    logic            ertn_o;
    logic            flush_o;
    logic [31:0]     redirect_pc_o;
    logic            stall_o;
    logic [63:0]     retired_cnt_o;
    logic [1:0]      dbg_state_o;

    rob_commit_unit_if cmt_bus ();

    rob_commit_unit #(.COMMIT_WIDTH(2), .ARCH_REG_NUM(32), .PHY_REG_NUM(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmt_i         (cmt_bus),
        .eentry_i      (eentry_i),
        .era_i         (era_i),
        .intr_i        (intr_i),
        .arat_we_o     (arat_we_o),
        .arat_idx_o    (arat_idx_o),
        .arat_preg_o   (arat_preg_o),
        .fl_free_o     (fl_free_o),
        .fl_preg_o     (fl_preg_o),
        .bpu_upd_o     (bpu_upd_o),
        .excp_o        (excp_o),
        .ertn_o        (ertn_o),
        .flush_o       (flush_o),
        .redirect_pc_o (redirect_pc_o),
        .stall_o       (stall_o),
        .retired_cnt_o (retired_cnt_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_v;
    int            chk = 0;
    int            err = 0;
    logic [63:0]   cnt_m;

    logic [1:0]      e_we;
    logic [1:0][4:0] e_idx;
    logic [1:0][5:0] e_preg;
    logic [1:0]      e_free;
    logic [1:0][5:0] e_fp;
    BpuUpdateSt      e_bpu;
    CmtExcpSt        e_x;
    logic            e_ertn;
    logic            e_flush;
    logic [31:0]     e_rp;
    logic            e_stall;

    // Fields without their qualifying valid are don't-care and zeroed.
    function automatic logic [OW-1:0] pack_out(
        input logic [1:0] we, input logic [1:0][4:0] idx, input logic [1:0][5:0] preg,
        input logic [1:0] fr, input logic [1:0][5:0] fp, input BpuUpdateSt b,
        input CmtExcpSt x, input logic ertn, input logic fl, input logic [31:0] rp,
        input logic st, input logic [63:0] cnt);
        for (int i = 0; i < 2; i++) begin
            if (!we[i]) begin idx[i] = '0; preg[i] = '0; end
            if (!fr[i]) fp[i] = '0;
        end
        if (!b.valid) b = '0;
        if (!x.valid) x = '0;
        if (!fl) rp = '0;
        return {we, idx, preg, fr, fp, b, x, ertn, fl, rp, st, cnt};
    endfunction

    function automatic logic [OW-1:0] obs_now();
        return pack_out(arat_we_o, arat_idx_o, arat_preg_o, fl_free_o, fl_preg_o, bpu_upd_o,
                        excp_o, ertn_o, flush_o, redirect_pc_o, stall_o, retired_cnt_o);
    endfunction

    function automatic RobEntrySt mk_alu(input logic [31:0] pc, input logic [4:0] a,
                                         input logic [5:0] p, input logic [5:0] o,
                                         input logic ov);
        RobEntrySt e;
        e = '0;
        e.pc = pc; e.instr_type = ALU_INSTR; e.arch_reg = a;
        e.phy_reg = p; e.old_phy_reg = o; e.old_phy_reg_valid = ov;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_cmt(input logic [1:0] v, input RobEntrySt e0, input RobEntrySt e1);
        cmt_bus.cmt.valid        = v;
        cmt_bus.cmt.rob_entry[0] = e0;
        cmt_bus.cmt.rob_entry[1] = e1;
    endtask

    task automatic clr_cmt();
        cmt_bus.cmt = '0;
    endtask

    task automatic clear_exp();
        e_we = '0; e_idx = '0; e_preg = '0; e_free = '0; e_fp = '0;
        e_bpu = '0; e_x = '0; e_ertn = 1'b0; e_flush = 1'b0; e_rp = '0; e_stall = 1'b0;
    endtask

    task automatic push_exp();
        exp_q.push_back(pack_out(e_we, e_idx, e_preg, e_free, e_fp, e_bpu, e_x,
                                 e_ertn, e_flush, e_rp, e_stall, cnt_m));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; intr_i = 1'b0; eentry_i = '0; era_i = '0; clr_cmt();
        cnt_m = '0;
        repeat (2) @(negedge clk);
        clear_exp(); push_exp();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL reset_outs got=%h exp=%h", obs_now(), exp_v); end
        chk++;
        if (redirect_pc_o !== 32'h0) begin err++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc_o); end
        chk++;
        if (dbg_state_o !== CMT_RUN) begin err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state_o, CMT_RUN); end
        rst = 1'b0;
    endtask

    task automatic test_two_alu();
        set_cmt(2'b11, mk_alu(32'h1c000000, 5'd3, 6'd10, 6'd5, 1'b1),
                       mk_alu(32'h1c000004, 5'd4, 6'd11, 6'd6, 1'b1));
        cnt_m = cnt_m + 2;
        clear_exp();
        e_we = 2'b11; e_idx[0] = 5'd3; e_idx[1] = 5'd4; e_preg[0] = 6'd10; e_preg[1] = 6'd11;
        e_free = 2'b11; e_fp[0] = 6'd5; e_fp[1] = 6'd6;
        push_exp();
        @(negedge clk); clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL two_alu got=%h exp=%h", obs_now(), exp_v); end
        clear_exp(); push_exp();
        @(negedge clk);
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL two_alu_idle got=%h exp=%h", obs_now(), exp_v); end
    endtask

    task automatic test_same_arch();
        set_cmt(2'b11, mk_alu(32'h1c000010, 5'd7, 6'd12, 6'd8, 1'b1),
                       mk_alu(32'h1c000014, 5'd7, 6'd13, 6'd12, 1'b1));
        cnt_m = cnt_m + 2;
        clear_exp();
        e_we = 2'b10; e_idx[1] = 5'd7; e_preg[1] = 6'd13;
        e_free = 2'b11; e_fp[0] = 6'd8; e_fp[1] = 6'd12;
        push_exp();
        @(negedge clk); clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL same_arch got=%h exp=%h", obs_now(), exp_v); end
    endtask

    task automatic test_bpu_pick();
        RobEntrySt b0, b1;
        b0 = mk_alu(32'h1c000020, 5'd1, 6'd40, 6'd41, 1'b1);
        b0.instr_type = BR_INSTR; b0.br_type = 2'd2; b0.br_taken = 1'b1; b0.br_target = 32'h1c000080;
        b1 = mk_alu(32'h1c000024, 5'd0, 6'd0, 6'd0, 1'b0);
        b1.instr_type = BR_INSTR; b1.br_type = 2'd1; b1.br_taken = 1'b0; b1.br_target = 32'h1c000090;
        // both slots are branches: oldest wins
        set_cmt(2'b11, b0, b1);
        cnt_m = cnt_m + 2;
        clear_exp();
        e_we = 2'b01; e_idx[0] = 5'd1; e_preg[0] = 6'd40; e_free = 2'b01; e_fp[0] = 6'd41;
        e_bpu = '{valid: 1'b1, pc: 32'h1c000020, br_type: 2'd2, taken: 1'b1, target: 32'h1c000080};
        push_exp();
        @(negedge clk);
        // only slot 1 is a branch
        set_cmt(2'b11, mk_alu(32'h1c000028, 5'd2, 6'd42, 6'd43, 1'b0), b1);
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL bpu_first got=%h exp=%h", obs_now(), exp_v); end
        cnt_m = cnt_m + 2;
        clear_exp();
        e_bpu = '{valid: 1'b1, pc: 32'h1c000024, br_type: 2'd1, taken: 1'b0, target: 32'h1c000090};
        push_exp();
        @(negedge clk); clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL bpu_slot1 got=%h exp=%h", obs_now(), exp_v); end
    endtask

    task automatic test_br_redirect();
        RobEntrySt b0;
        b0 = mk_alu(32'h1c0000f0, 5'd0, 6'd0, 6'd0, 1'b0);
        b0.instr_type = BR_INSTR; b0.br_redirect = 1'b1; b0.br_target = 32'h1c000100;
        b0.br_type = 2'd1; b0.br_taken = 1'b1;
        set_cmt(2'b11, b0, mk_alu(32'h1c0000f4, 5'd5, 6'd20, 6'd21, 1'b1));
        cnt_m = cnt_m + 1;
        clear_exp();
        e_bpu = '{valid: 1'b1, pc: 32'h1c0000f0, br_type: 2'd1, taken: 1'b1, target: 32'h1c000100};
        e_flush = 1'b1; e_rp = 32'h1c000100;
        push_exp();
        @(negedge clk);
        // commit offered while flushing must be ignored
        set_cmt(2'b11, mk_alu(32'h1c000100, 5'd9, 6'd22, 6'd23, 1'b1),
                       mk_alu(32'h1c000104, 5'd10, 6'd24, 6'd25, 1'b1));
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL br_redirect got=%h exp=%h", obs_now(), exp_v); end
        clear_exp(); push_exp();
        @(negedge clk); clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL br_flush_cycle got=%h exp=%h", obs_now(), exp_v); end
    endtask

    task automatic test_exception();
        RobEntrySt x0;
        x0 = mk_alu(32'h1c000300, 5'd2, 6'd30, 6'd31, 1'b1);
        x0.excp = '{valid: 1'b1, ecode: 6'h8, esubcode: 9'h0};
        x0.error_vaddr = 32'h1234;
        eentry_i = 32'h1c008000;
        set_cmt(2'b11, x0, mk_alu(32'h1c000304, 5'd3, 6'd32, 6'd33, 1'b1));
        clear_exp();
        e_x = '{valid: 1'b1, ecode: 6'h8, esubcode: 9'h0, pc: 32'h1c000300, badv: 32'h1234};
        e_flush = 1'b1; e_rp = 32'h1c008000;
        push_exp();
        @(negedge clk); clr_cmt(); eentry_i = 32'hdeadbeef;
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL exception got=%h exp=%h", obs_now(), exp_v); end
        clear_exp(); push_exp();
        @(negedge clk);
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL excp_flush_cycle got=%h exp=%h", obs_now(), exp_v); end
    endtask

    task automatic test_ertn();
        RobEntrySt r1;
        r1 = mk_alu(32'h1c000404, 5'd0, 6'd0, 6'd0, 1'b0);
        r1.instr_type = PRIV_INSTR; r1.ertn_flush = 1'b1;
        era_i = 32'h1c000400;
        set_cmt(2'b11, mk_alu(32'h1c000400, 5'd6, 6'd33, 6'd34, 1'b1), r1);
        cnt_m = cnt_m + 2;
        clear_exp();
        e_we = 2'b01; e_idx[0] = 5'd6; e_preg[0] = 6'd33; e_free = 2'b01; e_fp[0] = 6'd34;
        e_ertn = 1'b1; e_flush = 1'b1; e_rp = 32'h1c000400;
        push_exp();
        @(negedge clk); clr_cmt(); era_i = '0;
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL ertn got=%h exp=%h", obs_now(), exp_v); end
        @(negedge clk);
    endtask

    task automatic test_priv();
        RobEntrySt p0;
        p0 = mk_alu(32'h1c000500, 5'd8, 6'd40, 6'd41, 1'b1);
        p0.instr_type = PRIV_INSTR; p0.ibar_flush = 1'b1;
        set_cmt(2'b11, p0, mk_alu(32'h1c000504, 5'd9, 6'd42, 6'd43, 1'b1));
        cnt_m = cnt_m + 1;
        clear_exp();
        e_we = 2'b01; e_idx[0] = 5'd8; e_preg[0] = 6'd40; e_free = 2'b01; e_fp[0] = 6'd41;
        e_flush = 1'b1; e_rp = 32'h1c000504;
        push_exp();
        @(negedge clk); clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL priv got=%h exp=%h", obs_now(), exp_v); end
        @(negedge clk);
    endtask

    task automatic test_idle_wake();
        RobEntrySt i0;
        i0 = mk_alu(32'h1c000200, 5'd0, 6'd0, 6'd0, 1'b0);
        i0.instr_type = PRIV_INSTR; i0.idle_flush = 1'b1;
        intr_i = 1'b0;
        set_cmt(2'b11, i0, mk_alu(32'h1c000204, 5'd11, 6'd44, 6'd45, 1'b1));
        cnt_m = cnt_m + 1;
        clear_exp(); e_stall = 1'b1; push_exp();
        @(negedge clk);
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL idle_enter got=%h exp=%h", obs_now(), exp_v); end
        for (int k = 0; k < 5; k++) begin
            set_cmt(2'($urandom_range(0, 3)),
                    mk_alu(32'h1c000300, 5'($urandom_range(0, 31)), 6'd46, 6'd47, 1'b1),
                    mk_alu(32'h1c000304, 5'($urandom_range(0, 31)), 6'd48, 6'd49, 1'b1));
            clear_exp(); e_stall = 1'b1; push_exp();
            @(negedge clk);
            exp_v = exp_q.pop_front(); chk++;
            if (obs_now() !== exp_v) begin err++; $display("FAIL sleep_hold%0d got=%h exp=%h", k, obs_now(), exp_v); end
        end
        intr_i = 1'b1;
        clear_exp(); e_flush = 1'b1; e_rp = 32'h1c000204; push_exp();
        @(negedge clk); intr_i = 1'b0; clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL idle_wake got=%h exp=%h", obs_now(), exp_v); end
        clear_exp(); push_exp();
        @(negedge clk);
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL wake_flush_cycle got=%h exp=%h", obs_now(), exp_v); end
    endtask

    task automatic test_idle_intr_same();
        RobEntrySt i0;
        i0 = mk_alu(32'h1c000600, 5'd0, 6'd0, 6'd0, 1'b0);
        i0.idle_flush = 1'b1;
        intr_i = 1'b1;
        set_cmt(2'b01, i0, '0);
        cnt_m = cnt_m + 1;
        clear_exp(); e_stall = 1'b1; push_exp();
        @(negedge clk); clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL idle_intr_enter got=%h exp=%h", obs_now(), exp_v); end
        clear_exp(); e_flush = 1'b1; e_rp = 32'h1c000604; push_exp();
        @(negedge clk); intr_i = 1'b0;
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL idle_intr_wake got=%h exp=%h", obs_now(), exp_v); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0]      v, ov;
        logic [1:0][4:0] a;
        logic [1:0][5:0] p, o;
        logic [1:0]      ok;
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(0, 3)); ov = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                a[i] = 5'($urandom_range(0, 3));
                p[i] = 6'($urandom_range(0, 63));
                o[i] = 6'($urandom_range(0, 63));
            end
            set_cmt(v, mk_alu(32'h1c001000 + 32'(8 * n), a[0], p[0], o[0], ov[0]),
                       mk_alu(32'h1c001004 + 32'(8 * n), a[1], p[1], o[1], ov[1]));
            ok = v & ov;
            clear_exp();
            e_free = ok;
            e_we[1] = ok[1];
            e_we[0] = ok[0] && !(ok[1] && a[1] == a[0]);
            e_idx = a; e_preg = p; e_fp = o;
            cnt_m = cnt_m + 64'(v[0]) + 64'(v[1]);
            push_exp();
            @(negedge clk);
            exp_v = exp_q.pop_front(); chk++;
            if (obs_now() !== exp_v) begin err++; $display("FAIL b2b%0d got=%h exp=%h", n, obs_now(), exp_v); end
        end
        clr_cmt();
        @(negedge clk);
    endtask

    task automatic test_reset_sleep();
        RobEntrySt i0;
        i0 = mk_alu(32'h1c000700, 5'd0, 6'd0, 6'd0, 1'b0);
        i0.idle_flush = 1'b1;
        intr_i = 1'b0;
        set_cmt(2'b01, i0, '0);
        cnt_m = cnt_m + 1;
        clear_exp(); e_stall = 1'b1; push_exp();
        @(negedge clk);
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL rs_enter got=%h exp=%h", obs_now(), exp_v); end
        rst = 1'b1; intr_i = 1'b1;
        set_cmt(2'b11, mk_alu(32'h1c000704, 5'd1, 6'd2, 6'd3, 1'b1),
                       mk_alu(32'h1c000708, 5'd4, 6'd5, 6'd6, 1'b1));
        cnt_m = '0;
        clear_exp(); push_exp();
        @(negedge clk); rst = 1'b0; clr_cmt();
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL rs_reset got=%h exp=%h", obs_now(), exp_v); end
        chk++;
        if (redirect_pc_o !== 32'h0) begin err++; $display("FAIL rs_redirect got=%h exp=0", redirect_pc_o); end
        clear_exp(); push_exp();
        @(negedge clk); intr_i = 1'b0;
        exp_v = exp_q.pop_front(); chk++;
        if (obs_now() !== exp_v) begin err++; $display("FAIL rs_no_pulse got=%h exp=%h", obs_now(), exp_v); end
        chk++;
        if (dbg_state_o !== CMT_RUN) begin err++; $display("FAIL rs_state got=%0d exp=%0d", dbg_state_o, CMT_RUN); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_two_alu();
        test_same_arch();
        test_bpu_pick();
        test_br_redirect();
        test_exception();
        test_ertn();
        test_priv();
        test_idle_wake();
        test_idle_intr_same();
        test_back_to_back();
        test_reset_sleep();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
